// File: rtl/alu_pkg.sv
// Shared definitions for the ALU output stage: operation codes, default widths
// and the bit layout of the captured result packet.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    // 3-bit operation select codes
    localparam logic [2:0] ALU_SEL_AND = 3'b000;
    localparam logic [2:0] ALU_SEL_OR  = 3'b001;
    localparam logic [2:0] ALU_SEL_XOR = 3'b010;
    localparam logic [2:0] ALU_SEL_NOR = 3'b011;
    localparam logic [2:0] ALU_SEL_ADD = 3'b100;
    localparam logic [2:0] ALU_SEL_SUB = 3'b101;
    localparam logic [2:0] ALU_SEL_SLT = 3'b110;
    localparam logic [2:0] ALU_SEL_ILL = 3'b111;

    // Packet = {result, zero, ovf, illegal}; flags sit in the low bits
    localparam int PKT_FLAG_W = 3;
    localparam int PKT_ILL    = 0;
    localparam int PKT_OVF    = 1;
    localparam int PKT_ZERO   = 2;

endpackage

// File: rtl/alu_result_mux.sv
// Combinational result select with zero / overflow / illegal flag generation.
module alu_result_mux
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] and_res,
    input  logic [WIDTH-1:0] or_res,
    input  logic [WIDTH-1:0] xor_res,
    input  logic [WIDTH-1:0] nor_res,
    input  logic [WIDTH-1:0] add_res,
    input  logic [WIDTH-1:0] sub_res,
    input  logic [WIDTH-1:0] slt_res,
    input  logic             add_ovf,
    input  logic             sub_ovf,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    // Pick the candidate and derive flags; overflow only exists for ADD/SUB
    always_comb begin
        result  = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (alu_sel)
            ALU_SEL_AND: result = and_res;
            ALU_SEL_OR:  result = or_res;
            ALU_SEL_XOR: result = xor_res;
            ALU_SEL_NOR: result = nor_res;
            ALU_SEL_ADD: begin
                result = add_res;
                ovf    = add_ovf;
            end
            ALU_SEL_SUB: begin
                result = sub_res;
                ovf    = sub_ovf;
            end
            ALU_SEL_SLT: result = slt_res;
            ALU_SEL_ILL: illegal = 1'b1;
            default:     illegal = 1'b1;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU output stage: selects one candidate result, captures it with its flags
// as a single packet, and presents it through a main register backed by a
// one-entry skid so in_ready is a plain register output.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] and_res,
    input  logic [WIDTH-1:0] or_res,
    input  logic [WIDTH-1:0] xor_res,
    input  logic [WIDTH-1:0] nor_res,
    input  logic [WIDTH-1:0] add_res,
    input  logic [WIDTH-1:0] sub_res,
    input  logic [WIDTH-1:0] slt_res,
    input  logic             add_ovf,
    input  logic             sub_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic [CNT_W-1:0] out_count
);

    localparam int PKT_W = WIDTH + PKT_FLAG_W;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&c) ? c : (c + one);
    endfunction

    logic [WIDTH-1:0] sel_result_p0;
    logic             sel_zero_p0;
    logic             sel_ovf_p0;
    logic             sel_ill_p0;
    logic [PKT_W-1:0] pkt_p0;

    logic [PKT_W-1:0] pkt_p1;       // main register, drives out_*
    logic             vld_p1;
    logic [PKT_W-1:0] skid_pkt_p1;  // overflow slot while downstream stalls
    logic             skid_vld_p1;
    logic [CNT_W-1:0] count_q;

    logic in_fire;
    logic out_fire;
    logic main_load;

    alu_result_mux #(.WIDTH(WIDTH)) u_mux (
        .alu_sel (alu_sel),
        .and_res (and_res),
        .or_res  (or_res),
        .xor_res (xor_res),
        .nor_res (nor_res),
        .add_res (add_res),
        .sub_res (sub_res),
        .slt_res (slt_res),
        .add_ovf (add_ovf),
        .sub_ovf (sub_ovf),
        .result  (sel_result_p0),
        .zero    (sel_zero_p0),
        .ovf     (sel_ovf_p0),
        .illegal (sel_ill_p0)
    );

    // ---- stage p0: combinational packet, handshake decode ----
    assign pkt_p0    = {sel_result_p0, sel_zero_p0, sel_ovf_p0, sel_ill_p0};
    assign in_ready  = !skid_vld_p1;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = vld_p1 && out_ready;
    assign main_load = in_fire && (!vld_p1 || out_ready);

    // ---- stage p1: main/skid registers, refilled from skid first ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_p1      <= '0;
            vld_p1      <= 1'b0;
            skid_pkt_p1 <= '0;
            skid_vld_p1 <= 1'b0;
        end else if (out_fire && skid_vld_p1) begin
            pkt_p1      <= skid_pkt_p1;
            skid_vld_p1 <= 1'b0;
        end else if (main_load) begin
            pkt_p1 <= pkt_p0;
            vld_p1 <= 1'b1;
        end else if (in_fire) begin
            skid_pkt_p1 <= pkt_p0;
            skid_vld_p1 <= 1'b1;
        end else if (out_fire) begin
            vld_p1 <= 1'b0;
        end
    end

    // Count delivered results, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (out_fire) begin
            count_q <= sat_inc(count_q);
        end
    end

    assign out_valid   = vld_p1;
    assign out_result  = pkt_p1[PKT_W-1:PKT_FLAG_W];
    assign out_zero    = pkt_p1[PKT_ZERO];
    assign out_ovf     = pkt_p1[PKT_OVF];
    assign out_illegal = pkt_p1[PKT_ILL];
    assign out_count   = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; a second instance with CNT_W=4
// shares all inputs to exercise counter saturation.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         out_ready;
    logic [2:0]   alu_sel;
    logic [W-1:0] and_res, or_res, xor_res, nor_res, add_res, sub_res, slt_res;
    logic         add_ovf, sub_ovf;

    logic         in_ready, out_valid, out_zero, out_ovf, out_illegal;
    logic [W-1:0] out_result;
    logic [15:0]  out_count;

    logic         in_ready4, out_valid4, out_zero4, out_ovf4, out_illegal4;
    logic [W-1:0] out_result4;
    logic [3:0]   out_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .and_res(and_res), .or_res(or_res), .xor_res(xor_res),
        .nor_res(nor_res), .add_res(add_res), .sub_res(sub_res), .slt_res(slt_res),
        .add_ovf(add_ovf), .sub_ovf(sub_ovf), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
        .out_ovf(out_ovf), .out_illegal(out_illegal), .out_count(out_count)
    );

    alu_result_stage #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .alu_sel(alu_sel), .and_res(and_res), .or_res(or_res), .xor_res(xor_res),
        .nor_res(nor_res), .add_res(add_res), .sub_res(sub_res), .slt_res(slt_res),
        .add_ovf(add_ovf), .sub_ovf(sub_ovf), .out_valid(out_valid4),
        .out_ready(out_ready), .out_result(out_result4), .out_zero(out_zero4),
        .out_ovf(out_ovf4), .out_illegal(out_illegal4), .out_count(out_count4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Distinct background on every candidate; the selected one carries val
    task automatic put(input logic [2:0] sel, input logic [31:0] val,
                       input logic aovf, input logic sovf);
        alu_sel = sel;
        and_res = 32'h1111_1111;
        or_res  = 32'h2222_2222;
        xor_res = 32'h3333_3333;
        nor_res = 32'h4444_4444;
        add_res = 32'h5555_5555;
        sub_res = 32'h6666_6666;
        slt_res = 32'h0000_0001;
        add_ovf = aovf;
        sub_ovf = sovf;
        case (sel)
            3'b000:  and_res = val;
            3'b001:  or_res  = val;
            3'b010:  xor_res = val;
            3'b011:  nor_res = val;
            3'b100:  add_res = val;
            3'b101:  sub_res = val;
            3'b110:  slt_res = val;
            default: ;
        endcase
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        put(3'b000, 32'h0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", out_result, 32'd0);
        chk("rst_flags", {29'b0, out_zero, out_ovf, out_illegal}, 32'd0);
        chk("rst_count", {16'b0, out_count}, 32'd0);
        reset = 1'b0;

        // 1: OR select, one-cycle latency, delivered count
        put(ALU_SEL_OR, 32'hF0F0_0F0F, 1'b0, 1'b0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_result", out_result, 32'hF0F0_0F0F);
        chk("t1_zero", {31'b0, out_zero}, 32'd0);
        step();
        chk("t1_drain", {31'b0, out_valid}, 32'd0);
        chk("t1_hold", out_result, 32'hF0F0_0F0F);
        chk("t1_count", {16'b0, out_count}, 32'd1);

        // 2: ADD zero with overflow, then OR ignores add_ovf
        put(ALU_SEL_ADD, 32'h0, 1'b1, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t2_add_res", out_result, 32'd0);
        chk("t2_add_zero", {31'b0, out_zero}, 32'd1);
        chk("t2_add_ovf", {31'b0, out_ovf}, 32'd1);
        step();
        put(ALU_SEL_OR, 32'h0, 1'b1, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t2_or_zero", {31'b0, out_zero}, 32'd1);
        chk("t2_or_ovf", {31'b0, out_ovf}, 32'd0);
        step();
        chk("t2_count", {16'b0, out_count}, 32'd3);

        // 3: backpressure, skid fills, third push refused, in-order release
        out_ready = 1'b0;
        put(ALU_SEL_XOR, 32'd1, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        chk("t3_a_valid", {31'b0, out_valid}, 32'd1);
        chk("t3_a_ready", {31'b0, in_ready}, 32'd1);
        put(ALU_SEL_SUB, 32'd2, 1'b0, 1'b1);
        step();
        chk("t3_b_ready", {31'b0, in_ready}, 32'd0);
        chk("t3_b_hold", out_result, 32'd1);
        put(ALU_SEL_SUB, 32'd3, 1'b0, 1'b0);
        step();
        chk("t3_c_ready", {31'b0, in_ready}, 32'd0);
        chk("t3_c_hold", out_result, 32'd1);
        chk("t3_c_ovf", {31'b0, out_ovf}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t3_second", out_result, 32'd2);
        chk("t3_second_ovf", {31'b0, out_ovf}, 32'd1);
        chk("t3_second_v", {31'b0, out_valid}, 32'd1);
        chk("t3_ready_back", {31'b0, in_ready}, 32'd1);
        step();
        chk("t3_empty", {31'b0, out_valid}, 32'd0);
        chk("t3_count", {16'b0, out_count}, 32'd5);

        // 4: 100-packet stream, no bubbles
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            put(ALU_SEL_ADD, i + 1, 1'b0, 1'b0);
            step();
            chk("t4_valid", {31'b0, out_valid}, 32'd1);
            chk("t4_result", out_result, i + 1);
        end
        in_valid = 1'b0;
        step();
        chk("t4_empty", {31'b0, out_valid}, 32'd0);
        chk("t4_count", {16'b0, out_count}, 32'd105);
        chk("t4_sat4", {28'b0, out_count4}, 32'd15);

        // 5: illegal code forces zero result, next legal op clears it
        put(ALU_SEL_ILL, 32'h0, 1'b1, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t5_ill", {31'b0, out_illegal}, 32'd1);
        chk("t5_result", out_result, 32'd0);
        chk("t5_zero", {31'b0, out_zero}, 32'd1);
        chk("t5_ovf", {31'b0, out_ovf}, 32'd0);
        step();
        put(ALU_SEL_AND, 32'd5, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t5_clear", {31'b0, out_illegal}, 32'd0);
        chk("t5_and", out_result, 32'd5);
        chk("t5_and_zero", {31'b0, out_zero}, 32'd0);
        step();
        chk("t5_count", {16'b0, out_count}, 32'd107);
        chk("t5_sat4", {28'b0, out_count4}, 32'd15);

        // 6: reset while main and skid are both full
        out_ready = 1'b0;
        put(ALU_SEL_SLT, 32'd1, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        step();
        chk("t6_full", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_ready", {31'b0, in_ready}, 32'd1);
        chk("t6_count", {16'b0, out_count}, 32'd0);
        chk("t6_count4", {28'b0, out_count4}, 32'd0);
        chk("t6_result", out_result, 32'd0);
        step();
        chk("t6_no_ghost", {31'b0, out_valid}, 32'd0);
        put(ALU_SEL_NOR, 32'd9, 1'b0, 1'b0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t6_after", out_result, 32'd9);
        step();
        chk("t6_after_cnt", {16'b0, out_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
